debug_access_sequencer: RTL and testbench

- APB-slave front end for the BE8 debugger: accepts one APB transfer at a time and sequences the debugger microcode ROM.
- Halts the CPU, drives ADDR/WRITE/STEP into the microcode, and steps STEP until the microcode asserts its ready bit.
- Moves data between the APB bus and the shared 8-bit CPU bus, then completes the APB transfer.
- Sits between the external debug port and the microcode ROM / CPU bus.

---
 rtl/debug_access_sequencer_pkg.sv | 16 +
 rtl/debug_access_sequencer_if.sv | 26 ++
 rtl/debug_access_sequencer.sv | 145 ++++++++++++++
 tb/tb_debug_access_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/debug_access_sequencer_pkg.sv
// rtl/debug_access_sequencer_pkg.sv - shared widths, defaults and state type for the debug access sequencer
// Package debug_pkg: imported by the APB interface and the sequencer.
package debug_pkg;
    localparam int ADDR_W            = 5;
    localparam int DATA_W            = 8;
    localparam int STEP_W            = 2;
    localparam int MAX_STEP_DEFAULT  = 3;
    localparam int HALT_WAIT_DEFAULT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HALT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } dbg_state_e;
endpackage

// File: rtl/debug_access_sequencer_if.sv
// rtl/debug_access_sequencer_if.sv - APB slave port bundle of the debug access sequencer
// Signals: psel, penable, pwrite, paddr, pwdata (master -> slave);
//          prdata, pready, pslverr (slave -> master).
// Modports: master (debug port side), slave (sequencer side).
interface debug_access_sequencer_if;
    import debug_pkg::*;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/debug_access_sequencer.sv
// rtl/debug_access_sequencer.sv - APB front end that halts the CPU and steps the debugger microcode
// Optional feature macro: DBG_HALT_TIMEOUT_EN (HALT gives up after HALT_WAIT_MAX cycles).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   apb (slave)           one APB transfer at a time; pready only in DONE
//   mc_addr/write/step    microcode ROM inputs (addr/write valid in RUN)
//   mc_pready             microcode: transfer finishes at this step
//   mc_paddr_or_pwdata    bus_out source: 1 = latched address, 0 = latched data
//   mc_outreg_or_bus      capture bus_in into prdata this step
//   mc_do_n               active-low CPU bus drive enable
//   bus_out, bus_oe       CPU bus drive
//   bus_in                CPU bus readback
//   cpu_halt_req          held from HALT through RUN
//   cpu_halted            CPU halt acknowledge
module debug_access_sequencer
    import debug_pkg::*;
#(
    parameter int MAX_STEP = MAX_STEP_DEFAULT
`ifdef DBG_HALT_TIMEOUT_EN
    ,
    parameter int HALT_WAIT_MAX = HALT_WAIT_DEFAULT
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    debug_access_sequencer_if.slave  apb,
    output logic [ADDR_W-1:0]        mc_addr,
    output logic                     mc_write,
    output logic [STEP_W-1:0]        mc_step,
    input  logic                     mc_pready,
    input  logic                     mc_paddr_or_pwdata,
    input  logic                     mc_outreg_or_bus,
    input  logic                     mc_do_n,
    output logic [DATA_W-1:0]        bus_out,
    output logic                     bus_oe,
    input  logic [DATA_W-1:0]        bus_in,
    output logic                     cpu_halt_req,
    input  logic                     cpu_halted
);
    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_HALT = 2'(HALT);
    localparam logic [1:0] S_RUN  = 2'(RUN);
    localparam logic [1:0] S_DONE = 2'(DONE);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MAX_STEP);

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [STEP_W-1:0] step_q;
    logic              err_q;
    logic [DATA_W-1:0] prdata_q;
    logic              run;
    logic              halt_expired;

`ifdef DBG_HALT_TIMEOUT_EN
    localparam logic [3:0] HALT_LAST = 4'(HALT_WAIT_MAX - 1);

    logic [3:0] halt_cnt;

    // Counts cycles spent in HALT; cleared whenever we are elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_cnt <= '0;
        end else if (state == S_HALT) begin
            halt_cnt <= halt_cnt + 4'd1;
        end else begin
            halt_cnt <= '0;
        end
    end

    assign halt_expired = (halt_cnt == HALT_LAST);
`else
    assign halt_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            step_q   <= '0;
            err_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Only the APB setup phase starts a transfer; anything
                    // seen while busy is ignored.
                    if (apb.psel && !apb.penable) begin
                        addr_q  <= apb.paddr;
                        wdata_q <= apb.pwdata;
                        write_q <= apb.pwrite;
                        state   <= S_HALT;
                    end
                end
                S_HALT: begin
                    // A late acknowledge still wins over an expiring timeout.
                    if (cpu_halted) begin
                        step_q <= '0;
                        state  <= S_RUN;
                    end else if (halt_expired) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_RUN: begin
                    if (mc_outreg_or_bus) begin
                        prdata_q <= bus_in;
                    end
                    if (mc_pready) begin
                        state <= S_DONE;
                    end else if (step_q == LAST_STEP) begin
                        // Microcode ran out of steps without finishing.
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                default: begin
                    step_q <= '0;
                    err_q  <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state so reset forces them low without
    // waiting for a clock edge.
    assign run          = (state == S_RUN);
    assign mc_addr      = run ? addr_q : '0;
    assign mc_write     = run & write_q;
    assign mc_step      = step_q;
    assign bus_oe       = run & ~mc_do_n;
    assign bus_out      = !run ? '0 :
                          mc_paddr_or_pwdata ? {{(DATA_W-ADDR_W){1'b0}}, addr_q} : wdata_q;
    assign cpu_halt_req = (state == S_HALT) || run;
    assign apb.pready   = (state == S_DONE);
    assign apb.pslverr  = (state == S_DONE) & err_q;
    assign apb.prdata   = prdata_q;
endmodule

// File: tb/tb_debug_access_sequencer.sv
// tb/tb_debug_access_sequencer.sv - randomized self-checking bench for debug_access_sequencer
module tb_debug_access_sequencer;
    import debug_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] mc_addr;
    logic       mc_write;
    logic [1:0] mc_step;
    logic       mc_pready = 1'b0;
    logic       mc_paddr_or_pwdata = 1'b0;
    logic       mc_outreg_or_bus = 1'b0;
    logic       mc_do_n = 1'b1;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in = 8'h00;
    logic       cpu_halt_req;
    logic       cpu_halted = 1'b0;

    int         n_checks = 0;
    int         n_errors = 0;
    int         xfer_id = 0;
    logic [7:0] exp_prdata = 8'h00;

    debug_access_sequencer_if apb ();

    debug_access_sequencer dut (
        .clk                (clk),
        .rst                (rst),
        .apb                (apb),
        .mc_addr            (mc_addr),
        .mc_write           (mc_write),
        .mc_step            (mc_step),
        .mc_pready          (mc_pready),
        .mc_paddr_or_pwdata (mc_paddr_or_pwdata),
        .mc_outreg_or_bus   (mc_outreg_or_bus),
        .mc_do_n            (mc_do_n),
        .bus_out            (bus_out),
        .bus_oe             (bus_oe),
        .bus_in             (bus_in),
        .cpu_halt_req       (cpu_halt_req),
        .cpu_halted         (cpu_halted)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL xfer%0d %s: got 0x%0h expected 0x%0h", xfer_id, tag, got, exp);
        end
    endtask

    task automatic mc_idle();
        mc_do_n            = 1'b1;
        mc_paddr_or_pwdata = 1'b0;
        mc_outreg_or_bus   = 1'b0;
        mc_pready          = 1'b0;
        bus_in             = 8'h00;
    endtask

    // Access phase; in glitch mode the master misbehaves with random
    // select/enable and new address/data that must all be ignored.
    task automatic apb_access(input bit glitch);
        if (glitch) begin
            apb.psel    = 1'($urandom);
            apb.penable = 1'($urandom);
            apb.paddr   = 5'($urandom);
            apb.pwdata  = 8'($urandom);
            apb.pwrite  = 1'($urandom);
        end else begin
            apb.penable = 1'b1;
        end
    endtask

    // One APB transfer. The microcode program is given per step:
    // don/sel/outreg bit j and byte j of bin apply at step j; pr_step < 0
    // means the microcode never signals ready. d = cycles of HALT before
    // cpu_halted rises. rst_step >= 0 pulls reset during that RUN step.
    task automatic do_xfer(input logic wr, input logic [4:0] a, input logic [7:0] wd,
                           input int d, input int pr_step, input logic [3:0] don,
                           input logic [3:0] sel, input logic [3:0] outreg,
                           input logic [31:0] bin, input bit glitch, input int rst_step);
        int  halt_cycles;
        int  run_cycles;
        bit  timeout;
        bit  err;
        bit  aborted;
        logic [7:0] exp_bus;
        xfer_id++;
        timeout = 1'b0;
`ifdef DBG_HALT_TIMEOUT_EN
        if (d >= 15) timeout = 1'b1;
`endif
        halt_cycles = timeout ? 15 : d + 1;
        run_cycles  = timeout ? 0 : ((pr_step < 0) ? 4 : pr_step + 1);
        err         = timeout || (pr_step < 0);
        aborted     = 1'b0;

        @(negedge clk);
        apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = wr; apb.paddr = a; apb.pwdata = wd;
        cpu_halted = (d == 0);
        #1;
        check_val("setup_halt_req", cpu_halt_req, 0);
        check_val("setup_pready", apb.pready, 0);

        for (int i = 0; i < halt_cycles; i++) begin
            @(negedge clk);
            apb_access(glitch);
            cpu_halted = (i >= d);
            #1;
            check_val("halt_halt_req", cpu_halt_req, 1);
            check_val("halt_pready", apb.pready, 0);
            check_val("halt_bus_oe", bus_oe, 0);
        end

        for (int j = 0; j < run_cycles && !aborted; j++) begin
            @(negedge clk);
            apb_access(glitch);
            mc_do_n            = don[j];
            mc_paddr_or_pwdata = sel[j];
            mc_outreg_or_bus   = outreg[j];
            mc_pready          = (j == pr_step);
            bus_in             = bin[j*8 +: 8];
            exp_bus            = sel[j] ? {3'b000, a} : wd;
            #1;
            check_val("run_step", mc_step, j);
            check_val("run_addr", mc_addr, a);
            check_val("run_write", mc_write, wr);
            check_val("run_bus_oe", bus_oe, !don[j]);
            check_val("run_bus_out", bus_out, exp_bus);
            check_val("run_halt_req", cpu_halt_req, 1);
            check_val("run_pready", apb.pready, 0);
            if (j == rst_step) begin
                rst = 1'b1;
                #1;
                check_val("rst_bus_oe", bus_oe, 0);
                check_val("rst_halt_req", cpu_halt_req, 0);
                check_val("rst_pready", apb.pready, 0);
                check_val("rst_step", mc_step, 0);
                exp_prdata = 8'h00;
                aborted    = 1'b1;
            end else if (outreg[j]) begin
                exp_prdata = bin[j*8 +: 8];
            end
        end

        if (!aborted) begin
            @(negedge clk);
            apb_access(glitch);
            mc_idle();
            #1;
            check_val("done_pready", apb.pready, 1);
            check_val("done_pslverr", apb.pslverr, err);
            check_val("done_halt_req", cpu_halt_req, 0);
            check_val("done_bus_oe", bus_oe, 0);
            check_val("done_prdata", apb.prdata, exp_prdata);
        end

        @(negedge clk);
        rst = 1'b0;
        apb.psel = 1'b0; apb.penable = 1'b0;
        cpu_halted = 1'b0;
        mc_idle();
        #1;
        check_val("idle_pready", apb.pready, 0);
        check_val("idle_halt_req", cpu_halt_req, 0);
        check_val("idle_step", mc_step, 0);
        check_val("idle_prdata", apb.prdata, exp_prdata);
    endtask

    initial begin
        int   r;
        int   pr;
        int   rs;
        int   dmax;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0;
        repeat (2) @(negedge clk);
        #1;
        check_val("reset_pready", apb.pready, 0);
        check_val("reset_pslverr", apb.pslverr, 0);
        check_val("reset_prdata", apb.prdata, 0);
        check_val("reset_halt_req", cpu_halt_req, 0);
        check_val("reset_bus_oe", bus_oe, 0);
        check_val("reset_step", mc_step, 0);
        check_val("reset_addr", mc_addr, 0);
        rst = 1'b0;

        // Write 0x03/0xA5, drive data at step 0, ready at step 1.
        do_xfer(1'b1, 5'h03, 8'hA5, 0, 1, 4'b1110, 4'b0000, 4'b0000, 32'h0, 1'b0, -1);
        // Read 0x10, capture 0x3C at step 2 and finish there.
        do_xfer(1'b0, 5'h10, 8'h00, 0, 2, 4'b1111, 4'b0000, 4'b0100, 32'h003C_0000, 1'b0, -1);
        // Microcode never ready: runs to step 3 and errors.
        do_xfer(1'b1, 5'h07, 8'h5A, 0, -1, 4'b1111, 4'b1111, 4'b0000, 32'h0, 1'b0, -1);
        // Halt acknowledge delayed by 5 cycles.
        do_xfer(1'b0, 5'h1F, 8'h00, 5, 0, 4'b1111, 4'b0000, 4'b0001, 32'h0000_00C3, 1'b0, -1);
        // Reset while driving the bus in RUN, then a normal transfer.
        do_xfer(1'b1, 5'h0A, 8'h99, 0, -1, 4'b0000, 4'b0101, 4'b0000, 32'h0, 1'b0, 1);
        do_xfer(1'b1, 5'h15, 8'h42, 1, 0, 4'b0000, 4'b0001, 4'b0000, 32'h0, 1'b0, -1);
`ifdef DBG_HALT_TIMEOUT_EN
        // CPU never halts: timeout error, bus never driven.
        do_xfer(1'b1, 5'h02, 8'h11, 1000, 0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1'b0, -1);
        dmax = 20;
`else
        dmax = 6;
`endif

        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 4);
            pr = (r == 4) ? -1 : r;
            rs = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
            do_xfer(1'($urandom), 5'($urandom), 8'($urandom), $urandom_range(0, dmax), pr,
                    4'($urandom), 4'($urandom), 4'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0), rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
